// File: rtl/aes_hpc_host_driver.sv
// Host-side driver for a d-share HPC AES core: masks pt/key into shares, unmasks ciphertext.
// Optional build macro AES_DRV_ZERO_MASK_EN forces all masks to zero (MASK timing unchanged).
module aes_hpc_host_driver #(
  parameter int unsigned d = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [127:0]         pt,
  input  logic [127:0]         key,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic [127:0]         ct,
  input  logic                 reseed_valid,
  output logic                 reseed_ready,
  input  logic [79:0]          reseed,
  input  logic                 lfsr_load,
  input  logic [31:0]          lfsr_seed,
  output logic                 core_in_valid,
  input  logic                 core_in_ready,
  output logic [128*d-1:0]     core_shares_plaintext,
  output logic [128*d-1:0]     core_shares_key,
  output logic                 core_seed_valid,
  input  logic                 core_seed_ready,
  output logic [79:0]          core_seed,
  input  logic [128*d-1:0]     core_shares_ciphertext,
  input  logic                 core_out_valid,
  output logic                 core_out_ready
);

  localparam int unsigned SHARE_W     = 128 * d;
  localparam int unsigned PT_WORDS    = 4 * (d - 1);
  localparam int unsigned MASK_CYCLES = 8 * (d - 1);
  localparam int unsigned CNT_W       = $clog2(MASK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MASK_CYCLES - 1);
  localparam logic [31:0]      LFSR_TAPS = 32'h0040_0007;
  localparam logic [31:0]      LFSR_INIT = 32'h0000_0001;

  typedef enum logic [2:0] {IDLE, SEED, MASK, SEND, WAIT, OUT} state_t;

  state_t state, state_d;

  logic               core_in_valid_d, core_seed_valid_d, core_out_ready_d, ct_valid_d;
  logic               capture_pt, capture_seed, capture_ct, mask_en;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        lfsr, lfsr_next, mask;
  logic [SHARE_W-1:0] pt_sh_next, key_sh_next;
  logic [127:0]       ct_unmasked;

  // Galois LFSR, x^32 + x^22 + x^2 + x + 1 (left-shifting form)
  assign lfsr_next = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? LFSR_TAPS : 32'h0);

`ifdef AES_DRV_ZERO_MASK_EN
  assign mask = 32'h0;
`else
  assign mask = lfsr_next;
`endif

  // State and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      core_in_valid   <= 1'b0;
      core_seed_valid <= 1'b0;
      core_out_ready  <= 1'b0;
      ct_valid        <= 1'b0;
    end else begin
      state           <= state_d;
      core_in_valid   <= core_in_valid_d;
      core_seed_valid <= core_seed_valid_d;
      core_out_ready  <= core_out_ready_d;
      ct_valid        <= ct_valid_d;
    end
  end

  // Next state, next registered outputs, combinational host readies
  always_comb begin
    state_d           = state;
    core_in_valid_d   = core_in_valid;
    core_seed_valid_d = core_seed_valid;
    core_out_ready_d  = core_out_ready;
    ct_valid_d        = ct_valid;
    pt_ready          = 1'b0;
    reseed_ready      = 1'b0;
    capture_pt        = 1'b0;
    capture_seed      = 1'b0;
    capture_ct        = 1'b0;
    mask_en           = 1'b0;
    case (state)
      IDLE: begin
        if (reseed_valid) begin
          capture_seed      = 1'b1;
          core_seed_valid_d = 1'b1;
          state_d           = SEED;
        end else if (pt_valid) begin
          pt_ready   = 1'b1;
          capture_pt = 1'b1;
          state_d    = MASK;
        end
      end
      SEED: begin
        if (core_seed_ready) begin
          reseed_ready      = 1'b1;
          core_seed_valid_d = 1'b0;
          state_d           = IDLE;
        end
      end
      MASK: begin
        mask_en = 1'b1;
        if (cnt == CNT_LAST) begin
          core_in_valid_d = 1'b1;
          state_d         = SEND;
        end
      end
      SEND: begin
        if (core_in_ready) begin
          core_in_valid_d  = 1'b0;
          core_out_ready_d = 1'b1;
          state_d          = WAIT;
        end
      end
      WAIT: begin
        if (core_out_valid) begin
          capture_ct       = 1'b1;
          core_out_ready_d = 1'b0;
          ct_valid_d       = 1'b1;
          state_d          = OUT;
        end
      end
      OUT: begin
        if (ct_ready) begin
          ct_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mask word cnt lands in its share slot and is folded into share 0
  always_comb begin
    pt_sh_next  = core_shares_plaintext;
    key_sh_next = core_shares_key;
    for (int unsigned j = 1; j < d; j++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (cnt == CNT_W'(4 * (j - 1) + k)) begin
          pt_sh_next[128*j + 32*k +: 32] = mask;
          pt_sh_next[32*k +: 32]         = pt_sh_next[32*k +: 32] ^ mask;
        end
        if (cnt == CNT_W'(PT_WORDS + 4 * (j - 1) + k)) begin
          key_sh_next[128*j + 32*k +: 32] = mask;
          key_sh_next[32*k +: 32]         = key_sh_next[32*k +: 32] ^ mask;
        end
      end
    end
  end

  always_comb begin
    ct_unmasked = 128'h0;
    for (int unsigned j = 0; j < d; j++) begin
      ct_unmasked = ct_unmasked ^ core_shares_ciphertext[128*j +: 128];
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr                  <= LFSR_INIT;
      cnt                   <= '0;
      core_shares_plaintext <= '0;
      core_shares_key       <= '0;
      core_seed             <= 80'h0;
      ct                    <= 128'h0;
    end else begin
      if (state == IDLE && lfsr_load) begin
        lfsr <= (lfsr_seed == 32'h0) ? LFSR_INIT : lfsr_seed;
      end else if (mask_en) begin
        lfsr <= lfsr_next;
      end
      if (capture_seed) begin
        core_seed <= reseed;
      end
      if (capture_pt) begin
        core_shares_plaintext <= SHARE_W'(pt);
        core_shares_key       <= SHARE_W'(key);
        cnt                   <= '0;
      end else if (mask_en) begin
        core_shares_plaintext <= pt_sh_next;
        core_shares_key       <= key_sh_next;
        cnt                   <= cnt + CNT_W'(1);
      end
      if (capture_ct) begin
        ct <= ct_unmasked;
      end
    end
  end

endmodule

// File: doc/aes_hpc_host_driver.md
AES_HPC_HOST_DRIVER -- requirements
Module: aes_hpc_host_driver

Interface
REQ-001 SHALL have parameter d, default 2, number of shares (d >= 2).
REQ-002 SHALL have clk  input  1  clock; rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have pt_valid/pt_ready  in/out  1/1  host plaintext+key stream handshake; pt, key  input  128 each  unmasked data.
REQ-004 SHALL have ct_valid/ct_ready  out/in  1/1  host ciphertext handshake; ct  output  128  unmasked ciphertext.
REQ-005 SHALL have reseed_valid/reseed_ready  in/out  1/1  host reseed handshake; reseed  input  80  PRNG seed.
REQ-006 SHALL have lfsr_load  input  1  mask-LFSR load strobe; lfsr_seed  input  32  LFSR load value.
REQ-007 SHALL have core_in_valid/core_in_ready  out/in  1/1; core_shares_plaintext, core_shares_key  output  128*d each; share j at bits [128*j +: 128].
REQ-008 SHALL have core_seed_valid/core_seed_ready  out/in  1/1; core_seed  output  80.
REQ-009 SHALL have core_shares_ciphertext  input  128*d, same layout; core_out_valid/core_out_ready  in/out  1/1.

Function
REQ-010 SHALL implement FSM states IDLE, SEED, MASK, SEND, WAIT, OUT.
REQ-011 IDLE: reseed_valid=1 SHALL move to SEED, taking priority over pt_valid in the same cycle.
REQ-012 IDLE with pt_valid=1 and reseed_valid=0: pt_ready=1 for that cycle, pt/key captured, move to MASK.
REQ-013 SEED: core_seed_valid=1, core_seed=captured reseed, core_in_valid=0; the cycle core_seed_ready=1 (one-cycle pulse from core), reseed_ready=1 and move to IDLE.
REQ-014 Mask LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, steps once per MASK cycle; each post-step state is one mask word.
REQ-015 MASK SHALL last exactly 8*(d-1) cycles; word w<4(d-1) fills plaintext share 1+w/4 bits [32*(w%4) +: 32], following 4(d-1) words fill key shares identically.
REQ-016 Share 0 SHALL equal data XOR all masks 1..d-1, for plaintext and key independently.
REQ-017 SEND: core_in_valid=1, shares held stable until core_in_ready=1, then WAIT.
REQ-018 WAIT: core_out_ready=1; on core_out_valid=1, ct register = XOR of all d ciphertext shares, move to OUT.
REQ-019 OUT: ct_valid=1, ct stable until ct_ready=1, then IDLE; no new pt or reseed accepted before IDLE.
REQ-020 lfsr_load SHALL take effect only in IDLE; load value 0 SHALL be replaced by 32'h00000001.
REQ-021 Latency pt_ready pulse to core_in_valid rise SHALL be 8*(d-1)+1 cycles; core_out_valid to ct_valid SHALL be 1 cycle.
REQ-022 core_in_valid and core_seed_valid SHALL never be asserted in the same cycle.
REQ-023 pt_ready, reseed_ready SHALL be combinational on state and handshake inputs only; all other outputs registered.

Reset
REQ-024 On rst: state IDLE; pt_ready, ct_valid, reseed_ready, core_in_valid, core_seed_valid, core_out_ready = 0; ct, share registers, core_seed = 0; LFSR = 32'h00000001.
REQ-025 rst mid-transaction SHALL abandon it without emitting ct; driver and core SHALL share rst.

Configuration
REQ-026 Macro AES_DRV_ZERO_MASK_EN: defined, all masks forced 0 (share0 = data, shares 1..d-1 = 0), MASK timing unchanged, LFSR still steps; undefined, masks per REQ-014..016.

Verification
REQ-027 FIPS-197: key 000102..0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-028 During SEND: share0 XOR share1 == pt and == key respectively (d=2), share1 != 0 after lfsr_load seed 32'hdeadbeef.
REQ-029 reseed_valid and pt_valid both 1 in IDLE -> SEED entered, pt_ready=0, reseed_ready pulses with core_seed_ready, then pt accepted.
REQ-030 ct_ready held 0 for 10 cycles in OUT -> ct_valid=1 and ct stable all 10 cycles, pt_ready=0.
REQ-031 rst asserted during WAIT -> next cycle all outputs at reset values, ct_valid never asserted for that transaction.
REQ-032 AES_DRV_ZERO_MASK_EN defined -> core_shares_plaintext[255:128]=0, [127:0]=pt, MASK still 8 cycles.
